// File: rtl/pipelined_cla_alu.sv
// Two-stage pipelined ALU with a two-level carry-lookahead adder and valid/ready handshakes.
// Define ALU_OVERFLOW_EN to compute and register the signed-overflow output; otherwise ovf is tied to 0.
module pipelined_cla_alu #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             m,
   input  logic [1:0]       s,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             cout,
   output logic             zero,
   output logic             ovf
);

   localparam int GROUPS = WIDTH / 4;

   logic [WIDTH-1:0]  b_eff;
   logic [WIDTH-1:0]  bit_p;
   logic [WIDTH-1:0]  bit_g;
   logic [GROUPS-1:0] grp_p;
   logic [GROUPS-1:0] grp_g;
   logic              carry0;

   logic              s1_valid;
   logic [WIDTH-1:0]  s1_a;
   logic [WIDTH-1:0]  s1_b;
   logic              s1_c0;
   logic [GROUPS-1:0] s1_gp;
   logic [GROUPS-1:0] s1_gg;
   logic              s1_m;
   logic [1:0]        s1_s;

   logic              s2_valid;
   logic              s1_adv;
   logic              s2_adv;

   logic [GROUPS:0]   grp_c;
   logic [WIDTH-1:0]  bit_c;
   logic              run_p;
   logic [WIDTH-1:0]  res_y;
   logic              res_cout;

   // A stage may load when it is empty or its contents move on this cycle.
   assign s2_adv    = !s2_valid || out_ready;
   assign s1_adv    = !s1_valid || s2_adv;
   assign in_ready  = s1_adv;
   assign out_valid = s2_valid;

   // Stage 1: effective B operand, per-bit p/g and nibble-level group P/G.
   always_comb begin
      b_eff = (!m && s[1]) ? ~b : b;
      bit_p = a | b_eff;
      bit_g = a & b_eff;
      case (s)
         2'b00:   carry0 = 1'b0;
         2'b10:   carry0 = 1'b1;
         default: carry0 = cin;
      endcase
      grp_p = '0;
      grp_g = '0;
      for (int k = 0; k < GROUPS; k++) begin
         grp_p[k] = &bit_p[4*k +: 4];
         grp_g[k] = bit_g[4*k+3]
                  | (bit_p[4*k+3] & bit_g[4*k+2])
                  | (bit_p[4*k+3] & bit_p[4*k+2] & bit_g[4*k+1])
                  | (bit_p[4*k+3] & bit_p[4*k+2] & bit_p[4*k+1] & bit_g[4*k]);
      end
   end

   // Stage 2: each group carry is a flat sum of products over the lower group terms.
   always_comb begin
      grp_c    = '0;
      grp_c[0] = s1_c0;
      run_p    = 1'b0;
      for (int k = 0; k < GROUPS; k++) begin
         grp_c[k+1] = s1_gg[k];
         run_p      = s1_gp[k];
         for (int j = k - 1; j >= 0; j--) begin
            grp_c[k+1] = grp_c[k+1] | (run_p & s1_gg[j]);
            run_p      = run_p & s1_gp[j];
         end
         grp_c[k+1] = grp_c[k+1] | (run_p & s1_c0);
      end

      bit_c = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (i % 4 == 0)
            bit_c[i] = grp_c[i/4];
         else
            bit_c[i] = (s1_a[i-1] & s1_b[i-1]) | ((s1_a[i-1] | s1_b[i-1]) & bit_c[i-1]);
      end

      res_y    = '0;
      res_cout = 1'b0;
      if (!s1_m) begin
         res_y    = s1_a ^ s1_b ^ bit_c;
         res_cout = grp_c[GROUPS];
      end else begin
         case (s1_s)
            2'b00:   res_y = s1_a & s1_b;
            2'b01:   res_y = s1_a | s1_b;
            2'b10:   res_y = s1_a ^ s1_b;
            default: res_y = ~s1_a;
         endcase
      end
   end

   // Pipeline registers; data only loads alongside its valid bit so stalled results stay put.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         y        <= '0;
         cout     <= 1'b0;
         zero     <= 1'b0;
      end else begin
         if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
               s1_a  <= a;
               s1_b  <= b_eff;
               s1_c0 <= carry0;
               s1_gp <= grp_p;
               s1_gg <= grp_g;
               s1_m  <= m;
               s1_s  <= s;
            end
         end
         if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               y    <= res_y;
               cout <= res_cout;
               zero <= (res_y == '0);
            end
         end
      end
   end

`ifdef ALU_OVERFLOW_EN
   logic res_ovf;

   // Signed overflow: carry into the sign bit disagrees with the carry out of it.
   assign res_ovf = !s1_m && (bit_c[WIDTH-1] ^ grp_c[GROUPS]);

   always_ff @(posedge clk) begin
      if (rst)
         ovf <= 1'b0;
      else if (s2_adv && s1_valid)
         ovf <= res_ovf;
   end
`else
   assign ovf = 1'b0;
`endif

endmodule
